// File: rtl/neuron_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// neuron_layer_sequencer_if
// Bundle between the layer sequencer and its environment: the network
// controller (start/busy/done/err), the weight and input memories, the
// shared MAC neuron, and the output buffer.
//
//   master : the sequencer
//   slave  : controller + memories + neuron + output buffer
//
// Signals (direction seen from master):
//   start      in   begin a layer evaluation
//   busy       out  layer in progress
//   done       out  one-cycle pulse after the last output write
//   err        out  sticky: neuron not ready when its result was captured
//   w_addr     out  weight address j*K+i (memory has 1-cycle read latency)
//   w_data     in   weight read data
//   x_addr     out  input address i (memory has 1-cycle read latency)
//   x_data     in   input read data
//   rd_en      out  read strobe for both memories
//   nrn_rst    out  neuron clear
//   nrn_valid  out  neuron input-pair strobe
//   nrn_w      out  neuron weight operand (pass-through of w_data)
//   nrn_x      out  neuron input operand (pass-through of x_data)
//   nrn_out    in   neuron accumulator value
//   nrn_ready  in   neuron result ready
//   y_we       out  output buffer write enable
//   y_addr     out  output index j
//   y_data     out  activated result
// ---------------------------------------------------------------------------
interface neuron_layer_sequencer_if #(
  parameter int N = 10,
  parameter int K = 4,
  parameter int M = 3
);
  localparam int WAW = (M * K > 1) ? $clog2(M * K) : 1;
  localparam int XAW = (K > 1) ? $clog2(K) : 1;
  localparam int YAW = (M > 1) ? $clog2(M) : 1;

  logic           start;
  logic           busy;
  logic           done;
  logic           err;
  logic [WAW-1:0] w_addr;
  logic [N-1:0]   w_data;
  logic [XAW-1:0] x_addr;
  logic [N-1:0]   x_data;
  logic           rd_en;
  logic           nrn_rst;
  logic           nrn_valid;
  logic [N-1:0]   nrn_w;
  logic [N-1:0]   nrn_x;
  logic [N-1:0]   nrn_out;
  logic           nrn_ready;
  logic           y_we;
  logic [YAW-1:0] y_addr;
  logic [N-1:0]   y_data;

  modport master (
    input  start, w_data, x_data, nrn_out, nrn_ready,
    output busy, done, err, w_addr, x_addr, rd_en,
           nrn_rst, nrn_valid, nrn_w, nrn_x, y_we, y_addr, y_data
  );

  modport slave (
    output start, w_data, x_data, nrn_out, nrn_ready,
    input  busy, done, err, w_addr, x_addr, rd_en,
           nrn_rst, nrn_valid, nrn_w, nrn_x, y_we, y_addr, y_data
  );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_layer_sequencer
// Time-multiplexes one MAC neuron over a fully-connected layer of M neurons
// with K inputs each. Per neuron j: clear the neuron, stream K weight/input
// pairs (read strobe one cycle ahead of the neuron strobe to cover the
// memories' read latency), capture the accumulated result, optionally clamp
// negatives to zero, and write it to the output buffer at index j.
//
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset; aborts a layer in progress
//   bus  master side of neuron_layer_sequencer_if (controller, memories,
//        neuron and output buffer signals)
//
// Parameters: N data width, Q fractional bits (the neuron does the shift),
// K inputs per neuron, M neurons per layer, RELU clamp enable.
// ---------------------------------------------------------------------------
module neuron_layer_sequencer #(
  parameter int N    = 10,
  parameter int Q    = 9,
  parameter int K    = 4,
  parameter int M    = 3,
  parameter int RELU = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  neuron_layer_sequencer_if.master  bus
);
  localparam int WAW = (M * K > 1) ? $clog2(M * K) : 1;
  localparam int XAW = (K > 1) ? $clog2(K) : 1;
  localparam int YAW = (M > 1) ? $clog2(M) : 1;

  if (K < 1 || M < 1 || Q < 0 || Q >= N) begin : g_param_check
    $error("neuron_layer_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [YAW-1:0] r_j;          // neuron index
  logic [XAW-1:0] r_i;          // input index within the neuron
  logic           r_err;
  logic           r_nrn_valid;  // rd_en delayed to line up with read data
  logic           w_rd_en;

  // Operands go straight from the memories to the neuron.
  assign bus.nrn_w = bus.w_data;
  assign bus.nrn_x = bus.x_data;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next_state = S_CLEAR;
      S_CLEAR:   w_next_state = (K > 1) ? S_ISSUE : S_WAIT;
      S_ISSUE:   if (r_i == XAW'(K - 1)) w_next_state = S_WAIT;
      S_WAIT:    w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = (r_j == YAW'(M - 1)) ? S_DONE : S_CLEAR;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Counters, sticky error and the neuron strobe
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_j         <= '0;
      r_i         <= '0;
      r_err       <= 1'b0;
      r_nrn_valid <= 1'b0;
    end else begin
      r_nrn_valid <= w_rd_en;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_j   <= '0;
            r_err <= 1'b0;
          end
        end
        S_CLEAR: r_i <= XAW'(1);
        S_ISSUE: r_i <= r_i + 1'b1;
        S_CAPTURE: begin
          // The result is written regardless; err only records that the
          // neuron had not flagged it as valid.
          if (!bus.nrn_ready)       r_err <= 1'b1;
          if (r_j != YAW'(M - 1))   r_j   <= r_j + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic (Moore, plus the ReLU on the captured value). Everything
  // except nrn_rst is forced low while rst is high so the neuron stays
  // cleared and nothing downstream sees a stray strobe.
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rd_en       = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.nrn_valid = 1'b0;
    bus.nrn_rst   = rst;
    bus.w_addr    = '0;
    bus.x_addr    = '0;
    bus.y_we      = 1'b0;
    bus.y_addr    = '0;
    bus.y_data    = '0;
    if (!rst) begin
      bus.busy      = (r_state != S_IDLE);
      bus.err       = r_err;
      bus.nrn_valid = r_nrn_valid;
      case (r_state)
        S_CLEAR: begin
          // Pair 0 is fetched while the neuron is being cleared; its data
          // arrives together with the first nrn_valid.
          bus.nrn_rst = 1'b1;
          w_rd_en     = 1'b1;
          bus.w_addr  = WAW'(int'(r_j) * K);
        end
        S_ISSUE: begin
          w_rd_en    = 1'b1;
          bus.w_addr = WAW'(int'(r_j) * K + int'(r_i));
          bus.x_addr = r_i;
        end
        S_CAPTURE: begin
          bus.y_we   = 1'b1;
          bus.y_addr = r_j;
          bus.y_data = (RELU != 0 && bus.nrn_out[N-1]) ? '0 : bus.nrn_out;
        end
        S_DONE:  bus.done = 1'b1;
        default: ;
      endcase
    end
    bus.rd_en = w_rd_en;
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_layer_sequencer
// Two sequencers (RELU=1 and RELU=0) run side by side on identical memory
// contents, each driving its own behavioural MAC neuron. Expected outputs
// come from a layer-level reference: y[j] = sum_i floor(w[j][i]*x[i]/2^Q),
// wrapped to N bits, optionally clamped at zero.
// ---------------------------------------------------------------------------
module tb_neuron_layer_sequencer;
  localparam int N = 10;
  localparam int Q = 9;
  localparam int K = 4;
  localparam int M = 3;
  localparam int LAYER_CYC = M * (K + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic block_ready = 1'b0;

  always #5 clk = ~clk;

  neuron_layer_sequencer_if #(.N(N), .K(K), .M(M)) bus_a ();
  neuron_layer_sequencer_if #(.N(N), .K(K), .M(M)) bus_b ();

  neuron_layer_sequencer #(.N(N), .Q(Q), .K(K), .M(M), .RELU(1)) u_dut_relu (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  neuron_layer_sequencer #(.N(N), .Q(Q), .K(K), .M(M), .RELU(0)) u_dut_raw (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_a.start = start;
  assign bus_b.start = start;

  // ---------------- memories (1-cycle read latency) ----------------
  logic [N-1:0] wmem [M*K];
  logic [N-1:0] xmem [K];

  always @(posedge clk) begin
    if (bus_a.rd_en) begin
      bus_a.w_data <= wmem[bus_a.w_addr];
      bus_a.x_data <= xmem[bus_a.x_addr];
    end
    if (bus_b.rd_en) begin
      bus_b.w_data <= wmem[bus_b.w_addr];
      bus_b.x_data <= xmem[bus_b.x_addr];
    end
  end

  // ---------------- behavioural neurons ----------------
  function automatic logic [N-1:0] mac_term(input logic [N-1:0] w, input logic [N-1:0] x);
    int p;
    p = $signed(w) * $signed(x);
    return N'(p >>> Q);
  endfunction

  logic [N-1:0] acc_a, acc_b;
  logic         seen_a, seen_b;

  always @(posedge clk) begin
    if (bus_a.nrn_rst) begin
      acc_a  <= '0;
      seen_a <= 1'b0;
    end else if (bus_a.nrn_valid) begin
      acc_a  <= acc_a + mac_term(bus_a.nrn_w, bus_a.nrn_x);
      seen_a <= 1'b1;
    end
    if (bus_b.nrn_rst) begin
      acc_b  <= '0;
      seen_b <= 1'b0;
    end else if (bus_b.nrn_valid) begin
      acc_b  <= acc_b + mac_term(bus_b.nrn_w, bus_b.nrn_x);
      seen_b <= 1'b1;
    end
  end

  assign bus_a.nrn_out   = acc_a;
  assign bus_b.nrn_out   = acc_b;
  // Error injection: withhold ready during the capture of the last neuron.
  assign bus_a.nrn_ready = seen_a && !(block_ready && bus_a.y_we && bus_a.y_addr == 2'd2);
  assign bus_b.nrn_ready = seen_b;

  // ---------------- reference model ----------------
  logic [N-1:0] exp_relu [M];
  logic [N-1:0] exp_raw  [M];

  task automatic compute_ref();
    for (int j = 0; j < M; j++) begin
      int s;
      logic [N-1:0] raw;
      s = 0;
      for (int i = 0; i < K; i++)
        s += (int'($signed(wmem[j*K+i])) * int'($signed(xmem[i]))) >>> Q;
      raw = N'(s);
      exp_raw[j]  = raw;
      exp_relu[j] = raw[N-1] ? '0 : raw;
    end
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // ---------------- per-cycle observation ----------------
  int cyc = 0;            // rising edges so far
  int jn = 0;             // neuron index the bench expects next
  int vi = 0;             // pair index within the current neuron
  int vrun = 0;           // length of current nrn_valid run
  int rrun = 0;           // length of current nrn_rst run (outside rst)
  int last_rd_cyc = 0;
  int n_wr = 0;
  int n_done = 0;
  int last_done_cyc = 0;
  int n_overlap = 0;
  logic prev_busy = 1'b0;
  logic [N-1:0] y_log_relu [M];
  logic [N-1:0] y_log_raw  [M];

  // Advance one cycle and sample the DUTs on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus_a.nrn_rst && bus_a.nrn_valid) n_overlap++;
    if (rst) begin
      jn = 0; vi = 0; vrun = 0; rrun = 0; prev_busy = 1'b0;
    end else begin
      if (bus_a.busy && !prev_busy) jn = 0;
      prev_busy = bus_a.busy;
      if (bus_a.nrn_rst) begin
        rrun++;
        vi = 0;
      end else if (rrun != 0) begin
        check("nrn_rst_len", rrun, 1);
        rrun = 0;
      end
      if (bus_a.nrn_valid) begin
        check("pair_w", bus_a.nrn_w, wmem[jn*K+vi]);
        check("pair_x", bus_a.nrn_x, xmem[vi]);
        vi++;
        vrun++;
      end else if (vrun != 0) begin
        check("valid_len", vrun, K);
        vrun = 0;
      end
      if (bus_a.rd_en) last_rd_cyc = cyc;
      if (bus_a.y_we) begin
        check("we_after_last_issue", cyc - last_rd_cyc, 2);
        check("y_addr", bus_a.y_addr, jn);
        check("y_relu", bus_a.y_data, exp_relu[jn]);
        if (bus_a.y_addr < M) y_log_relu[bus_a.y_addr] = bus_a.y_data;
        jn++;
        n_wr++;
      end
      if (bus_b.y_we && bus_b.y_addr < M) begin
        check("y_raw", bus_b.y_data, exp_raw[bus_b.y_addr]);
        y_log_raw[bus_b.y_addr] = bus_b.y_data;
      end
      if (bus_a.done) begin
        n_done++;
        last_done_cyc = cyc;
      end
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int b = 0; b < budget && n_done == d0; b++) tick();
    check("done_seen", n_done - d0, 1);
  endtask

  // Start a layer, wait for it, and check timing, write count and err.
  // The sample after the accepting edge sees cycle "t0+1", so done sampled
  // at cyc d is cycle d+1 and must equal t0 + M*(K+2) + 1.
  task automatic run_layer(input string tag, input logic exp_err);
    int t0, wr0, d0;
    wr0 = n_wr;
    d0  = n_done;
    start = 1'b1;
    t0 = cyc + 1;
    tick();
    start = 1'b0;
    check({tag, "_busy_on_start"}, bus_a.busy, 1);
    check({tag, "_err_cleared"}, bus_a.err, 0);
    wait_done(d0, LAYER_CYC + 10);
    check({tag, "_done_cycle"}, last_done_cyc + 1 - t0, LAYER_CYC + 1);
    check({tag, "_writes"}, n_wr - wr0, M);
    tick();
    check({tag, "_idle_after_done"}, {bus_a.busy, bus_a.done}, 0);
    check({tag, "_err"}, bus_a.err, exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, wr0, d0, d1;
    logic found;

    // ---- reset state ----
    for (int i = 0; i < M*K; i++) wmem[i] = '0;
    for (int i = 0; i < K; i++)   xmem[i] = '0;
    compute_ref();
    repeat (3) tick();
    check("rst_flags", {bus_a.busy, bus_a.done, bus_a.err, bus_a.rd_en,
                        bus_a.nrn_valid, bus_a.y_we}, 0);
    check("rst_nrn_rst", bus_a.nrn_rst, 1);
    check("rst_addr_data", {bus_a.w_addr, bus_a.x_addr, bus_a.y_addr, bus_a.y_data}, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", bus_a.busy, 0);
    check("idle_nrn_rst", bus_a.nrn_rst, 0);

    // ---- basic layer ----
    for (int i = 0; i < K; i++) xmem[i] = 10'd128;
    for (int i = 0; i < K; i++) wmem[i] = 10'd256;
    for (int i = 0; i < K; i++) wmem[K+i] = 10'h300;
    wmem[2*K+0] = 10'd256;
    wmem[2*K+1] = 10'h380;
    wmem[2*K+2] = 10'd0;
    wmem[2*K+3] = 10'd511;
    compute_ref();
    run_layer("basic", 1'b0);
    check("basic_y0", y_log_relu[0], 256);
    check("basic_y1", y_log_relu[1], 0);
    check("basic_y2", y_log_relu[2], 159);
    check("raw_y0", y_log_raw[0], 256);
    check("raw_y1", y_log_raw[1], 10'h300);
    check("raw_y2", y_log_raw[2], 159);

    // ---- error flag ----
    block_ready = 1'b1;
    run_layer("errflag", 1'b1);
    block_ready = 1'b0;
    check("err_y2_written", y_log_relu[2], 159);
    repeat (3) tick();
    check("err_sticky", bus_a.err, 1);

    // ---- reset during ISSUE of neuron 1 ----
    wr0 = n_wr;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_err_cleared", bus_a.err, 0);
    found = 1'b0;
    for (int b = 0; b < 40 && !found; b++) begin
      if (bus_a.rd_en && bus_a.w_addr >= K + 1 && bus_a.w_addr <= 2*K - 1) found = 1'b1;
      else tick();
    end
    check("abort_reached_issue1", found, 1);
    rst = 1'b1;
    tick();
    check("abort_busy_drop", bus_a.busy, 0);
    check("abort_nrn_rst", bus_a.nrn_rst, 1);
    tick();
    check("abort_nrn_rst_held", bus_a.nrn_rst, 1);
    rst = 1'b0;
    repeat (30) tick();
    check("abort_writes", n_wr - wr0, 1);
    check("abort_stays_idle", bus_a.busy, 0);
    run_layer("after_abort", 1'b0);

    // ---- start while busy, then start held across done ----
    d0  = n_done;
    wr0 = n_wr;
    start = 1'b1;
    t0 = cyc + 1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    start = 1'b1;
    wait_done(d0, LAYER_CYC + 10);
    d1 = last_done_cyc;
    check("midstart_done_cycle", d1 + 1 - t0, LAYER_CYC + 1);
    tick();
    check("held_idle_gap", bus_a.busy, 0);
    tick();
    check("held_retrigger", {bus_a.busy, bus_a.nrn_rst}, 2'b11);
    start = 1'b0;
    wait_done(d0 + 1, LAYER_CYC + 10);
    check("held_done_gap", last_done_cyc - d1, LAYER_CYC + 2);
    check("held_done_count", n_done - d0, 2);
    check("held_writes", n_wr - wr0, 2*M);
    tick();

    // ---- randomized layers ----
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < M*K; i++) wmem[i] = N'($urandom);
      for (int i = 0; i < K; i++)   xmem[i] = N'($urandom);
      compute_ref();
      run_layer("rand", 1'b0);
      for (int j = 0; j < M; j++) check("rand_raw_log", y_log_raw[j], exp_raw[j]);
    end

    check("rst_valid_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
